// File: rtl/victim_cache_pkg.sv
// victim_cache_pkg: shared state encoding and request opcodes for the victim cache controller
package victim_cache_pkg;
    typedef enum logic [3:0] {
        IDLE, P_LOOK, P_CHK, P_RD, I_LOOK, I_CHK, I_EVRD, I_WB, I_WR, I_DS
    } vc_state_e;
    localparam logic VC_OP_PROBE  = 1'b0;
    localparam logic VC_OP_INSERT = 1'b1;
endpackage

// File: rtl/vc_way_select.sv
// vc_way_select: lowest-free-way priority encoder over the shadow valid vector
module vc_way_select #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] sv,
    output logic [WAY_W-1:0]    free_way,
    output logic                all_valid
);
    // scan from the top so the lowest clear index wins
    always_comb begin
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!sv[i]) free_way = WAY_W'(i);
        all_valid = &sv;
    end
endmodule

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: sequences probe/insert requests into tag_store strobes with victim writeback
module victim_cache_ctrl
    import victim_cache_pkg::*;
#(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS  = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    output logic                 resp_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 ts_lookup_en,
    output logic                 ts_read_en,
    output logic                 ts_write_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag,
    output logic [WAY_W-1:0]     ts_way,
    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);
    vc_state_e            state_q, state_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d, wb_tag_q, wb_tag_d;
    logic [WAY_W-1:0]     way_q, way_d, rr_q, rr_d, free_way;
    logic [NUM_WAYS-1:0]  sv_q, sv_d;
    logic                 dirty_q, dirty_d, dup_q, dup_d, all_valid;

    vc_way_select #(.NUM_WAYS(NUM_WAYS)) u_sel (
        .sv       (sv_q),
        .free_way (free_way),
        .all_valid(all_valid)
    );

    assign ts_dirty_clear = 1'b0;
    assign wb_tag         = wb_tag_q;

    // next-state, strobes and responses; shadow valid tracks the strobes issued this cycle
    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        dirty_d        = dirty_q;
        way_d          = way_q;
        dup_d          = dup_q;
        wb_tag_d       = wb_tag_q;
        rr_d           = rr_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_hit       = 1'b0;
        resp_way       = '0;
        resp_dirty     = 1'b0;
        wb_valid       = 1'b0;
        ts_lookup_en   = 1'b0;
        ts_read_en     = 1'b0;
        ts_write_en    = 1'b0;
        ts_valid_clear = 1'b0;
        ts_dirty_set   = 1'b0;
        ts_tag         = '0;
        ts_way         = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_d   = req_tag;
                    dirty_d = req_dirty;
                    state_d = (req_op == VC_OP_INSERT) ? I_LOOK : P_LOOK;
                end
            end
            P_LOOK, I_LOOK: begin
                ts_lookup_en = 1'b1;
                ts_tag       = tag_q;
                state_d      = (state_q == P_LOOK) ? P_CHK : I_CHK;
            end
            P_CHK: begin
                if (ts_hit) begin
                    way_d      = ts_hit_way;
                    ts_read_en = 1'b1;
                    ts_way     = ts_hit_way;
                    state_d    = P_RD;
                end else begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            P_RD: begin
                ts_valid_clear = 1'b1;
                ts_way         = way_q;
                resp_valid     = 1'b1;
                resp_hit       = 1'b1;
                resp_way       = way_q;
                resp_dirty     = ts_dirty_read;
                state_d        = IDLE;
            end
            I_CHK: begin
                dup_d = ts_hit;
                if (ts_hit || !all_valid) begin
                    way_d   = ts_hit ? ts_hit_way : free_way;
                    state_d = I_WR;
                end else begin
                    way_d      = rr_q;
                    ts_read_en = 1'b1;
                    ts_way     = rr_q;
                    rr_d       = rr_q + WAY_W'(1);
                    state_d    = I_EVRD;
                end
            end
            I_EVRD: begin
                if (ts_valid_read && ts_dirty_read) wb_tag_d = ts_tag_read;
                state_d = (ts_valid_read && ts_dirty_read) ? I_WB : I_WR;
            end
            I_WB: begin
                wb_valid = 1'b1;
                state_d  = wb_ready ? I_WR : I_WB;
            end
            I_WR: begin
                ts_write_en = 1'b1;
                ts_way      = way_q;
                ts_tag      = tag_q;
                resp_valid  = !dirty_q;
                resp_hit    = !dirty_q && dup_q;
                resp_way    = dirty_q ? '0 : way_q;
                state_d     = dirty_q ? I_DS : IDLE;
            end
            I_DS: begin
                ts_dirty_set = 1'b1;
                ts_way       = way_q;
                resp_valid   = 1'b1;
                resp_hit     = dup_q;
                resp_way     = way_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        sv_d = sv_q;
        if (ts_write_en) sv_d[ts_way] = 1'b1;
        if (ts_valid_clear) sv_d[ts_way] = 1'b0;
    end

    // state registers; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            dirty_q  <= 1'b0;
            way_q    <= '0;
            dup_q    <= 1'b0;
            wb_tag_q <= '0;
            rr_q     <= '0;
            sv_q     <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            dirty_q  <= dirty_d;
            way_q    <= way_d;
            dup_q    <= dup_d;
            wb_tag_q <= wb_tag_d;
            rr_q     <= rr_d;
            sv_q     <= sv_d;
        end
    end
endmodule
